// File: rtl/bp_fe_queue_buffer_pkg.sv
// Shared types and defaults for the FE->BE checkpointed queue buffer.
package bp_fe_queue_buffer_pkg;

    localparam int unsigned els_gp         = 8;
    localparam int unsigned vaddr_width_gp = 22;
    localparam int unsigned instr_width_gp = 32;
    localparam int unsigned exc_width_gp   = 2;

    typedef enum logic [exc_width_gp-1:0] {
        e_exc_none           = 2'd0,
        e_itlb_miss          = 2'd1,
        e_instr_access_fault = 2'd2,
        e_instr_page_fault   = 2'd3
    } bp_fe_queue_exc_e;

    // Pointer width carries one extra wrap bit above the index.
    function automatic int unsigned ptr_width(input int unsigned els);
        return $clog2(els) + 1;
    endfunction

endpackage

// File: rtl/bp_fe_queue_buffer_if.sv
// FE enqueue, BE read/commit/rewind and occupancy signals of the queue buffer.
interface bp_fe_queue_buffer_if #(
    parameter int unsigned els_p         = bp_fe_queue_buffer_pkg::els_gp,
    parameter int unsigned vaddr_width_p = bp_fe_queue_buffer_pkg::vaddr_width_gp,
    parameter int unsigned instr_width_p = bp_fe_queue_buffer_pkg::instr_width_gp,
    parameter int unsigned exc_width_p   = bp_fe_queue_buffer_pkg::exc_width_gp
) ();

    localparam int unsigned ptr_width_lp = bp_fe_queue_buffer_pkg::ptr_width(els_p);

    logic                     fe_v_i;
    logic [vaddr_width_p-1:0] fe_pc_i;
    logic [instr_width_p-1:0] fe_instr_i;
    logic [exc_width_p-1:0]   fe_exc_i;
    logic                     fe_ready_o;

    logic                     be_v_o;
    logic [vaddr_width_p-1:0] be_pc_o;
    logic [instr_width_p-1:0] be_instr_o;
    logic [exc_width_p-1:0]   be_exc_o;
    logic                     be_yumi_i;

    logic                     deq_v_i;
    logic                     roll_v_i;
    logic                     clr_v_i;
    logic [ptr_width_lp-1:0]  count_o;

    modport slave (
        input  fe_v_i, fe_pc_i, fe_instr_i, fe_exc_i,
        output fe_ready_o,
        output be_v_o, be_pc_o, be_instr_o, be_exc_o,
        input  be_yumi_i, deq_v_i, roll_v_i, clr_v_i,
        output count_o
    );

    modport master (
        output fe_v_i, fe_pc_i, fe_instr_i, fe_exc_i,
        input  fe_ready_o,
        input  be_v_o, be_pc_o, be_instr_o, be_exc_o,
        output be_yumi_i, deq_v_i, roll_v_i, clr_v_i,
        input  count_o
    );

endinterface

// File: rtl/bp_fe_queue_buffer_mem.sv
// Flop-array storage: one synchronous write port, one asynchronous read port.
module bp_fe_queue_buffer_mem #(
    parameter int unsigned els_p   = 8,
    parameter int unsigned width_p = 56
) (
    input  logic                     clk_i,
    input  logic                     w_v_i,
    input  logic [$clog2(els_p)-1:0] w_addr_i,
    input  logic [width_p-1:0]       w_data_i,
    input  logic [$clog2(els_p)-1:0] r_addr_i,
    output logic [width_p-1:0]       r_data_o
);

    logic [width_p-1:0] mem_r [els_p];

    // NOTE: storage has no reset; validity is tracked purely by the pointers,
    // so resetting the array would only cost reset fan-out.
    always_ff @(posedge clk_i) begin
        if (w_v_i) begin
            mem_r[w_addr_i] <= w_data_i;
        end
    end

    assign r_data_o = mem_r[r_addr_i];

endmodule

// File: rtl/bp_fe_queue_buffer.sv
// Checkpointed FIFO between FE and BE: speculative reads, commit (deq), rewind (roll), flush (clr).
module bp_fe_queue_buffer #(
    parameter int unsigned els_p         = bp_fe_queue_buffer_pkg::els_gp,
    parameter int unsigned vaddr_width_p = bp_fe_queue_buffer_pkg::vaddr_width_gp,
    parameter int unsigned instr_width_p = bp_fe_queue_buffer_pkg::instr_width_gp,
    parameter int unsigned exc_width_p   = bp_fe_queue_buffer_pkg::exc_width_gp
) (
    input logic                  clk_i,
    input logic                  reset_n_i,
    bp_fe_queue_buffer_if.slave  q
);

    import bp_fe_queue_buffer_pkg::*;

    localparam int unsigned lg_els_lp = $clog2(els_p);

    typedef logic [lg_els_lp:0] ptr_t;

    typedef struct packed {
        logic [vaddr_width_p-1:0] pc;
        logic [instr_width_p-1:0] instr;
        logic [exc_width_p-1:0]   exc;
    } entry_s;

    ptr_t   wptr_r, rptr_r, cptr_r;
    ptr_t   wptr_n, rptr_n, cptr_n;
    ptr_t   count;
    logic   enq_v;
    logic   be_v;
    entry_s w_entry, r_entry;

    // Status depends on registered pointers only, so reset reaches the outputs at once.
    assign count         = wptr_r - cptr_r;
    assign q.count_o     = count;
    assign q.fe_ready_o  = (count != ptr_t'(els_p));
    assign be_v          = (rptr_r != wptr_r);
    assign q.be_v_o      = be_v;
    assign enq_v         = q.fe_v_i & q.fe_ready_o;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        wptr_n = wptr_r + ptr_t'(enq_v);
        rptr_n = rptr_r + ptr_t'(q.be_yumi_i);
        cptr_n = cptr_r + ptr_t'(q.deq_v_i);
        if (q.clr_v_i) begin
            wptr_n = '0;
            rptr_n = '0;
            cptr_n = '0;
        end else if (q.roll_v_i) begin
            rptr_n = cptr_r + ptr_t'(q.deq_v_i);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all pointers
    // update together from the same pre-edge values.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wptr_r <= '0;
            rptr_r <= '0;
            cptr_r <= '0;
        end else begin
            wptr_r <= wptr_n;
            rptr_r <= rptr_n;
            cptr_r <= cptr_n;
        end
    end

    assign w_entry = '{pc: q.fe_pc_i, instr: q.fe_instr_i, exc: q.fe_exc_i};

    // A flushed enqueue must not leave its payload behind.
    bp_fe_queue_buffer_mem #(
        .els_p   (els_p),
        .width_p ($bits(entry_s))
    ) mem (
        .clk_i    (clk_i),
        .w_v_i    (enq_v & ~q.clr_v_i),
        .w_addr_i (wptr_r[lg_els_lp-1:0]),
        .w_data_i (w_entry),
        .r_addr_i (rptr_r[lg_els_lp-1:0]),
        .r_data_o (r_entry)
    );

    assign q.be_pc_o    = r_entry.pc;
    assign q.be_instr_o = r_entry.instr;
    assign q.be_exc_o   = r_entry.exc;

    a_yumi_legal: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        q.be_yumi_i |-> be_v);

    a_deq_legal: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        q.deq_v_i |-> (cptr_r != rptr_r));

    a_ptr_order: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        (ptr_t'(rptr_r - cptr_r) <= count) && (count <= ptr_t'(els_p)));

endmodule

// File: tb/tb_bp_fe_queue_buffer.sv
// Directed self-checking bench for bp_fe_queue_buffer with a list-based reference model.
module tb_bp_fe_queue_buffer;

    import bp_fe_queue_buffer_pkg::*;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    bp_fe_queue_buffer_if qif ();

    bp_fe_queue_buffer dut (
        .clk_i     (clk),
        .reset_n_i (reset_n),
        .q         (qif)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference: uncommitted entries oldest-first, plus how many of them BE has read.
    logic [21:0] model_q [$];
    int          model_rd;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] instr_of(input logic [21:0] pc);
        return {10'h2A5, pc};
    endfunction

    task automatic model_check(input string tag);
        int sz;
        sz = model_q.size();
        check({tag, " count"}, 64'(qif.count_o), 64'(sz));
        check({tag, " ready"}, 64'(qif.fe_ready_o), 64'(sz != 8));
        check({tag, " be_v"}, 64'(qif.be_v_o), 64'(model_rd < sz));
        if (model_rd < sz) begin
            check({tag, " pc"}, 64'(qif.be_pc_o), 64'(model_q[model_rd]));
            check({tag, " instr"}, 64'(qif.be_instr_o), 64'(instr_of(model_q[model_rd])));
            check({tag, " exc"}, 64'(qif.be_exc_o), 64'(model_q[model_rd][3:2]));
        end
    endtask

    task automatic drive(input logic fe_v, input logic [21:0] pc, input logic yumi,
                         input logic deq, input logic roll, input logic clr);
        qif.fe_v_i     = fe_v;
        qif.fe_pc_i    = pc;
        qif.fe_instr_i = instr_of(pc);
        qif.fe_exc_i   = pc[3:2];
        qif.be_yumi_i  = yumi;
        qif.deq_v_i    = deq;
        qif.roll_v_i   = roll;
        qif.clr_v_i    = clr;
    endtask

    // One clock: drive, advance the model, then sample 1ns after the edge.
    task automatic cyc(input string tag, input logic fe_v, input logic [21:0] pc,
                       input logic yumi, input logic deq, input logic roll, input logic clr);
        logic enq;
        drive(fe_v, pc, yumi, deq, roll, clr);
        enq = fe_v && (model_q.size() != 8);
        if (clr) begin
            model_q.delete();
            model_rd = 0;
        end else begin
            if (roll) begin
                if (deq) void'(model_q.pop_front());
                model_rd = 0;
            end else begin
                if (yumi) model_rd++;
                if (deq) begin
                    void'(model_q.pop_front());
                    model_rd--;
                end
            end
            if (enq) model_q.push_back(pc);
        end
        @(posedge clk);
        #1;
        model_check(tag);
    endtask

    task automatic do_reset(input string tag);
        reset_n = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        model_q.delete();
        model_rd = 0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_check(tag);
    endtask

    initial begin
        reset_n = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        model_rd = 0;

        // 1: reset and idle
        do_reset("t1 reset");
        cyc("t1 idle", 0, 22'h0, 0, 0, 0, 0);
        check("t1 ready", 64'(qif.fe_ready_o), 64'd1);
        check("t1 be_v", 64'(qif.be_v_o), 64'd0);
        check("t1 count", 64'(qif.count_o), 64'd0);

        // 2: fill, then read one and commit it; the deq cycle offers an entry that must be refused
        for (int i = 0; i < 8; i++) cyc("t2 fill", 1, 22'h100 + 22'(4 * i), 0, 0, 0, 0);
        check("t2 full ready", 64'(qif.fe_ready_o), 64'd0);
        check("t2 full count", 64'(qif.count_o), 64'd8);
        check("t2 full head", 64'(qif.be_pc_o), 64'h100);
        cyc("t2 yumi", 0, 22'h0, 1, 0, 0, 0);
        check("t2 yumi ready", 64'(qif.fe_ready_o), 64'd0);
        cyc("t2 deq", 1, 22'h300, 0, 1, 0, 0);
        check("t2 deq ready", 64'(qif.fe_ready_o), 64'd1);
        check("t2 deq count", 64'(qif.count_o), 64'd7);
        check("t2 deq head", 64'(qif.be_pc_o), 64'h104);

        // 3: read three, then rewind to the commit point
        do_reset("t3 reset");
        for (int i = 0; i < 8; i++) cyc("t3 fill", 1, 22'h100 + 22'(4 * i), 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc("t3 yumi", 0, 22'h0, 1, 0, 0, 0);
        check("t3 pre-roll head", 64'(qif.be_pc_o), 64'h10C);
        cyc("t3 roll", 0, 22'h0, 0, 0, 1, 0);
        check("t3 roll head", 64'(qif.be_pc_o), 64'h100);
        check("t3 roll count", 64'(qif.count_o), 64'd8);

        // 4: streaming enqueue/read/commit across two index wraps
        do_reset("t4 reset");
        for (int i = 0; i < 3; i++) cyc("t4 prefill", 1, 22'h400 + 22'(4 * i), 0, 0, 0, 0);
        for (int i = 0; i < 20; i++)
            cyc("t4 stream", 1, 22'h40C + 22'(4 * i), 1, logic'(model_rd > 0), 0, 0);
        check("t4 end count", 64'(qif.count_o), 64'd4);
        check("t4 end head", 64'(qif.be_pc_o), 64'h450);

        // 5: flush in the same cycle as an accepted enqueue
        check("t5 pre ready", 64'(qif.fe_ready_o), 64'd1);
        cyc("t5 clr", 1, 22'h200, 0, 0, 0, 1);
        check("t5 clr be_v", 64'(qif.be_v_o), 64'd0);
        check("t5 clr count", 64'(qif.count_o), 64'd0);
        cyc("t5 enq", 1, 22'h204, 0, 0, 0, 0);
        check("t5 head", 64'(qif.be_pc_o), 64'h204);

        // 6: roll + deq + yumi together, then asynchronous reset mid-stream
        cyc("t6 enq", 1, 22'h208, 0, 0, 0, 0);
        cyc("t6 enq", 1, 22'h20C, 0, 0, 0, 0);
        cyc("t6 yumi", 0, 22'h0, 1, 0, 0, 0);
        cyc("t6 yumi", 0, 22'h0, 1, 0, 0, 0);
        check("t6 pre count", 64'(qif.count_o), 64'd3);
        cyc("t6 roll", 0, 22'h0, 1, 1, 1, 0);
        check("t6 roll head", 64'(qif.be_pc_o), 64'h208);
        check("t6 roll count", 64'(qif.count_o), 64'd2);
        drive(1'b1, 22'h210, 1'b1, 1'b0, 1'b0, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        check("t6 async ready", 64'(qif.fe_ready_o), 64'd1);
        check("t6 async be_v", 64'(qif.be_v_o), 64'd0);
        check("t6 async count", 64'(qif.count_o), 64'd0);
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("t6 held count", 64'(qif.count_o), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
